// File: rtl/imem_loader.sv
// Boot-side program loader: streams words into instruction memory from BOOT_ADDR, then pulses start.
// Optional running checksum of the loaded program is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] chk_sum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   index_r;
  logic [ADDR_W:0]     word_count_r;
  logic                imem_we_r;
  logic [31:0]         imem_addr_r;
  logic [DATA_W-1:0]   imem_wdata_r;
  logic                hs_s;
  logic                clr_s;

  // Words are only consumed while loading; everything else ignores s_valid.
  assign hs_s = s_valid & (state_r == LOAD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_s      = state_r;
    clr_s        = 1'b0;
    s_ready      = 1'b0;
    start        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err_overflow = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_req) begin
          state_s = LOAD;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (hs_s) begin
          if (s_last) begin
            state_s = START;
          end else if (index_r == IDX_LAST) begin
            // Memory full without an end marker: the word is still written, then we stop.
            state_s = ERR;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      START: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_s = RUN;
      end
      RUN: begin
        done = 1'b1;
        if (load_req) begin
          state_s = LOAD;
          clr_s   = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      ERR: begin
        err_overflow = 1'b1;
        if (load_req) begin
          state_s = LOAD;
          clr_s   = 1'b1;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Word index and accepted-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_r      <= {ADDR_W{1'b0}};
      word_count_r <= {(ADDR_W+1){1'b0}};
    end else if (clr_s) begin
      index_r      <= {ADDR_W{1'b0}};
      word_count_r <= {(ADDR_W+1){1'b0}};
    end else if (hs_s) begin
      index_r      <= index_r + IDX_ONE;
      word_count_r <= word_count_r + CNT_ONE;
    end else begin
      index_r      <= index_r;
      word_count_r <= word_count_r;
    end
  end

  // Registered memory write port; address and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= BOOT_ADDR;
      imem_wdata_r <= {DATA_W{1'b0}};
    end else if (hs_s) begin
      imem_we_r    <= 1'b1;
      imem_addr_r  <= BOOT_ADDR + (32'(index_r) << 5'd2);
      imem_wdata_r <= s_data;
    end else begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= imem_addr_r;
      imem_wdata_r <= imem_wdata_r;
    end
  end

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign word_count = word_count_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] chk_sum_r;

  // Modular sum of every accepted word of the current load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sum_r <= {DATA_W{1'b0}};
    end else if (clr_s) begin
      chk_sum_r <= {DATA_W{1'b0}};
    end else if (hs_s) begin
      chk_sum_r <= chk_sum_r + s_data;
    end else begin
      chk_sum_r <= chk_sum_r;
    end
  end

  assign chk_sum = chk_sum_r;
`else
  assign chk_sum = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a wide instance (ADDR_W=10) and a tiny one (ADDR_W=2) for overflow.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        lr_a = 1'b0;
  logic        lr_b = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        sv_a, sv_b;

  always #5 clk = ~clk;

  assign sv_a = s_valid & ~sel;
  assign sv_b = s_valid & sel;

  logic        rdy_a, we_a, st_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wd_a, cs_a;
  logic [10:0] wc_a;
  logic        rdy_b, we_b, st_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wd_b, cs_b;
  logic [2:0]  wc_b;

  imem_loader #(.ADDR_W(10), .DATA_W(32), .BOOT_ADDR(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_req(lr_a), .s_valid(sv_a), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a), .start(st_a),
    .busy(busy_a), .done(done_a), .err_overflow(err_a), .word_count(wc_a), .chk_sum(cs_a)
  );

  imem_loader #(.ADDR_W(2), .DATA_W(32), .BOOT_ADDR(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_req(lr_b), .s_valid(sv_b), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b), .start(st_b),
    .busy(busy_b), .done(done_b), .err_overflow(err_b), .word_count(wc_b), .chk_sum(cs_b)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          st_cnt_a = 0;
  int          st_cnt_b = 0;
  int          st0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [31:0] idx_a = 32'h0, idx_b = 32'h0, sum_a = 32'h0, sum_b = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_cs(input logic [31:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req();
    if (sel) begin lr_b = 1'b1; idx_b = 32'h0; sum_b = 32'h0; end
    else     begin lr_a = 1'b1; idx_a = 32'h0; sum_a = 32'h0; end
    step();
    lr_a = 1'b0;
    lr_b = 1'b0;
  endtask

  // Present one word; the expected write is queued before the handshake edge.
  task automatic send(input logic [31:0] d, input logic last);
    logic [31:0] a;
    a = sel ? (idx_b << 2) : (idx_a << 2);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    check("s_ready_in_load", {63'h0, (sel ? rdy_b : rdy_a)}, 64'h1);
    if (sel) begin q_b.push_back({a, d}); idx_b++; sum_b += d; end
    else     begin q_a.push_back({a, d}); idx_a++; sum_a += d; end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_reset_a();
    check("rst_s_ready", {63'h0, rdy_a}, 64'h0);
    check("rst_imem_we", {63'h0, we_a}, 64'h0);
    check("rst_flags", {60'h0, st_a, busy_a, done_a, err_a}, 64'h0);
    check("rst_addr", {32'h0, addr_a}, 64'h0);
    check("rst_wdata", {32'h0, wd_a}, 64'h0);
    check("rst_word_count", {53'h0, wc_a}, 64'h0);
    check("rst_chk_sum", {32'h0, cs_a}, 64'h0);
  endtask

  // Write monitors: every imem_we must match the oldest queued write.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (q_a.size() == 0) check("a_we_unexpected", {63'h0, we_a}, 64'h0);
      else check("a_write", {addr_a, wd_a}, q_a.pop_front());
    end
    if (we_b === 1'b1) begin
      if (q_b.size() == 0) check("b_we_unexpected", {63'h0, we_b}, 64'h0);
      else check("b_write", {addr_b, wd_b}, q_b.pop_front());
    end
    if (st_a === 1'b1) st_cnt_a++;
    if (st_b === 1'b1) st_cnt_b++;
  end

  initial begin
    // Power-on reset.
    #2;
    check_reset_a();
    check("rst_b_err", {63'h0, err_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a load.
    sel = 1'b0;
    req();
    send(32'hA0A0_0001, 1'b0);
    send(32'hA0A0_0002, 1'b0);
    send(32'hA0A0_0003, 1'b0);
    #1;
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check_reset_a();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic four-word program.
    st0 = st_cnt_a;
    req();
    send(32'h2008_0005, 1'b0);
    send(32'h2009_000C, 1'b0);
    send(32'h0109_5020, 1'b0);
    send(32'hAC0A_0000, 1'b1);
    @(negedge clk);
    check("start_pulse", {62'h0, st_a, busy_a}, 64'h3);
    step();
    @(negedge clk);
    check("start_drop", {63'h0, st_a}, 64'h0);
    check("done_run", {62'h0, done_a, busy_a}, 64'h2);
    check("wc_4", {53'h0, wc_a}, 64'd4);
    check("start_count_1", st_cnt_a - st0, 1);
    check("chk_sum_prog", {32'h0, cs_a}, {32'h0, exp_cs(sum_a)});
    step();

    // Gappy stream with an ignored load_req during loading.
    req();
    for (int i = 0; i < 5; i++) begin
      send(32'h1000_0000 + 32'(i) * 32'h0101_0101, (i == 4));
      if (i < 4) begin
        if (i == 1) lr_a = 1'b1;
        step();
        lr_a = 1'b0;
      end
    end
    step();
    @(negedge clk);
    check("gap_wc_5", {53'h0, wc_a}, 64'd5);
    check("gap_done", {63'h0, done_a}, 64'h1);
    step();
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("run_not_ready", {63'h0, rdy_a}, 64'h0);
    step();
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("run_wc_hold", {53'h0, wc_a}, 64'd5);
    step();

    // Reload from RUN.
    st0 = st_cnt_a;
    req();
    @(negedge clk);
    check("reload_done_drop", {62'h0, done_a, busy_a}, 64'h1);
    check("reload_wc_clr", {53'h0, wc_a}, 64'h0);
    step();
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b1);
    step();
    @(negedge clk);
    check("reload_start_count", st_cnt_a - st0, 1);
    check("reload_wc_2", {53'h0, wc_a}, 64'd2);
    step();

    // Checksum wraps modulo 2**32.
    req();
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b1);
    step();
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("chk_sum_wrap", {32'h0, cs_a}, 64'h1);
`else
    check("chk_sum_zero", {32'h0, cs_a}, 64'h0);
`endif
    step();

    // Overflow on the 4-word instance.
    sel = 1'b1;
    req();
    send(32'h0000_0011, 1'b0);
    send(32'h0000_0022, 1'b0);
    send(32'h0000_0033, 1'b0);
    send(32'h0000_0044, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h0000_0055;
    @(negedge clk);
    check("ovf_flags", {61'h0, err_b, rdy_b, busy_b}, 64'h4);
    check("ovf_wc_4", {61'h0, wc_b}, 64'd4);
    step();
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("ovf_no_start", st_cnt_b, 0);
    check("ovf_wc_hold", {61'h0, wc_b}, 64'd4);
    step();
    req();
    @(negedge clk);
    check("ovf_reload", {61'h0, err_b, rdy_b, busy_b}, 64'h3);
    check("ovf_reload_wc", {61'h0, wc_b}, 64'h0);
    step();
    send(32'h0000_00A1, 1'b0);
    send(32'h0000_00A2, 1'b0);
    send(32'h0000_00A3, 1'b0);
    send(32'h0000_00A4, 1'b1);
    step();
    @(negedge clk);
    check("full_prog_start", st_cnt_b, 1);
    check("full_prog_flags", {62'h0, done_b, err_b}, 64'h2);
    check("full_prog_wc", {61'h0, wc_b}, 64'd4);
    check("full_prog_sum", {32'h0, cs_b}, {32'h0, exp_cs(sum_b)});
    step();
    sel = 1'b0;

    step();
    check("a_queue_drained", 64'(q_a.size()), 64'h0);
    check("b_queue_drained", 64'(q_b.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
